pwm_peripheral: RTL
===================

# pwm_peripheral

Downstream consumer of the SPI register file. It turns the five configuration bytes (output enables, PWM-mode enables, duty cycle) into 16 registered output pins. Each pin is forced low, held static high, or driven by one shared 8-bit PWM waveform. The duty cycle is double-buffered so that a period never glitches mid-cycle.

## Interface
- PRESCALE, default 13: system clocks per PWM counter tick (≥1); period = 256·PRESCALE clocks.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM-mode select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM-mode select, channels 15..8
- pwm_duty_cycle  input  8  requested duty; 0x00 = 0 %, 0xFF = 100 %
- out  output  16  channel outputs, bit i = channel i

## Operation
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, `rst_n`.
- Input sourcing: all config inputs are quasi-static registers written from the same clock domain, so no synchronizers are needed.
- Prescaler:
  - `pre_cnt` counts 0..PRESCALE-1 and wraps.
  - `tick` is high on the cycle where `pre_cnt == PRESCALE-1`.
  - With PRESCALE = 1, `tick` is constant 1.
- Period counter: `pwm_cnt` is 8-bit. It increments on `tick` and wraps 255 → 0 naturally.
- Duty shadow:
  - `duty_sh` loads `pwm_duty_cycle` on the cycle where `tick && pwm_cnt == 255`, i.e. the same edge at which `pwm_cnt` becomes 0.
  - A write mid-period takes effect only at the next period start.
- Shared waveform: `pwm_sig = (duty_sh == 8'hFF) ? 1 : (pwm_cnt < duty_sh)`.
  - 0x00 gives constant low.
  - 0x80 gives 128 of 256 ticks high.
  - 0xFF gives constant high, with no one-tick dropout.
- Channel mux, per channel i, with `en_out` = {en_reg_out_15_8, en_reg_out_7_0} and `en_pwm` likewise:
  - `en_out[i] = 0` → 0, regardless of `en_pwm`.
  - `en_out[i] = 1`, `en_pwm[i] = 0` → 1.
  - `en_out[i] = 1`, `en_pwm[i] = 1` → `pwm_sig`.
- Register state: `out` is a registered copy of the mux result. There are no other state machines.

## Timing
- Reset values: `pre_cnt` = 0, `pwm_cnt` = 0, `duty_sh` = 0x00, `out` = 16'h0000.
- Release from reset:
  - First `tick` occurs PRESCALE cycles after the first active edge.
  - The first period runs with `duty_sh` = 0, so PWM channels stay low until the first reload, i.e. 256·PRESCALE cycles after reset release.
- Enable latency: a change on any enable input appears on `out` exactly 1 clock later.
- Waveform latency: `out` reflects `pwm_cnt`/`duty_sh` with 1 clock of latency, and this latency is constant.
  - The high phase for duty D lasts exactly D·PRESCALE clocks per period for 0 < D < 255.
- Duty update latency: between 1 and 256·PRESCALE clocks; the write is visible from the first tick of the next period.
- Duty written on the reload cycle itself: the value present on that exact clock is captured.
- Reset mid-period: all state clears immediately (asynchronous). `out` goes low without waiting for a clock.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_WIDTH` = 8
  - `NUM_CH` = 16
  - `DUTY_FULL` = 8'hFF
  - default `PRESCALE`
- One sub-module, `pwm_tick_gen`:
  - Parameter: PRESCALE.
  - Ports: clk, rst_n, tick output.
  - Contains only the prescaler counter, which makes PRESCALE sweeps testable in isolation.
- Everything else lives in the top module: period counter, shadow register, compare, 16-way mux and output register.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-period with all enables 0xFF and duty 0xFF → `out` = 0x0000 asynchronously; after release, PWM pins stay low for the first 256·PRESCALE cycles.
- **Static modes:** en_out = 0x00FF, en_pwm = 0x0000 → `out` = 0x00FF one clock after the write. Then set en_out = 0x0000 with en_pwm = 0xFFFF → `out` = 0x0000.
- **Duty 50 %:** duty = 0x80, en_out = en_pwm = 0xFFFF, PRESCALE = 13, after the first reload → each pin high for 1664 clocks and low for 1664, period 3328.
- **Duty extremes:** duty = 0x00 gives constant 0 over 2 full periods; duty = 0xFF gives constant 1 with no low cycle; duty = 0x01 gives high for exactly 13 clocks per period.
- **Double buffering:** set duty 0x40, then write 0xC0 when `pwm_cnt` = 100 → the current period keeps its high width of 64 ticks; the next period has a high width of 192 ticks.
- **PRESCALE = 1 build:** duty 0x03 → 3 clocks high, 253 clocks low, period 256; `tick` is constantly high.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and the duty-compare helper for the PWM peripheral.
// Imported by the interface, the tick generator and the top module.
package pwm_pkg;

  localparam int PWM_WIDTH        = 8;
  localparam int NUM_CH           = 16;
  localparam int PRESCALE_DEFAULT = 13;

  localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_WIDTH-1:0] CNT_LAST  = 8'hFF;

  // Full scale is forced high so 0xFF has no one-tick dropout at count 255.
  function automatic logic pwm_level(input logic [PWM_WIDTH-1:0] cnt,
                                     input logic [PWM_WIDTH-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Configuration bundle from the SPI register file into the PWM peripheral.
// The register file drives it (master); the peripheral consumes it (slave).
interface pwm_if;
  import pwm_pkg::*;

  logic [PWM_WIDTH-1:0] en_reg_out_7_0;
  logic [PWM_WIDTH-1:0] en_reg_out_15_8;
  logic [PWM_WIDTH-1:0] en_reg_pwm_7_0;
  logic [PWM_WIDTH-1:0] en_reg_pwm_15_8;
  logic [PWM_WIDTH-1:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler: divides clk by PRESCALE and pulses tick on the last count.
// With PRESCALE = 1 the counter is a single bit pinned at zero, so tick is constant 1.
module pwm_tick_gen #(
  parameter int PRESCALE = pwm_pkg::PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_reg;
  logic [CW-1:0] pre_cnt_next;

  always_comb begin
    pre_cnt_next = pre_cnt_reg + CW'(1);
    if (pre_cnt_reg == PRE_LAST) begin
      pre_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

  assign tick = (pre_cnt_reg == PRE_LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: per-pin force-low / static-high / shared PWM,
// with a duty shadow register reloaded only at period start.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_if.slave              cfg,
  output logic [NUM_CH-1:0] out
);

  logic                 tick;
  logic [PWM_WIDTH-1:0] pwm_cnt_reg;
  logic [PWM_WIDTH-1:0] duty_sh_reg;
  logic [NUM_CH-1:0]    out_reg;
  logic [NUM_CH-1:0]    out_next;
  logic [NUM_CH-1:0]    en_out;
  logic [NUM_CH-1:0]    en_pwm;
  logic                 pwm_sig;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
  assign en_pwm = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};

  // Duty is captured on the same edge that wraps the counter to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
      duty_sh_reg <= '0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_WIDTH'(1);
      if (pwm_cnt_reg == CNT_LAST) begin
        duty_sh_reg <= cfg.pwm_duty_cycle;
      end
    end
  end

  assign pwm_sig = pwm_level(pwm_cnt_reg, duty_sh_reg);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign out_next[gi] = en_out[gi] & (~en_pwm[gi] | pwm_sig);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  assign out = out_reg;

endmodule
